// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = a - b (mod 2^WIDTH), LSB first,
// one bit per clock. The operands sit in right-shifting registers, and a
// borrow flop links one bit stage to the next. The result collects in a
// shift register and appears on diff only when the operation completes.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  // Counter value on the last SHIFT edge of an operation.
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Full-subtractor difference bit: two chained half-subtractors.
  function automatic logic sub_bit(input logic x, input logic y, input logic bin);
    sub_bit = x ^ y ^ bin;
  endfunction

  // Full-subtractor borrow: the first half-subtractor borrows when x=0 and y=1.
  // The second borrows when the first half-difference is 0 and a borrow comes in.
  function automatic logic sub_borrow(input logic x, input logic y, input logic bin);
    sub_borrow = (~x & y) | (~(x ^ y) & bin);
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  logic             bit_diff;
  logic             bit_borrow;

  // This stage's difference bit and outgoing borrow, taken from the operand LSBs.
  always_comb begin
    bit_diff   = sub_bit(sa_q[0], sb_q[0], br_q);
    bit_borrow = sub_borrow(sa_q[0], sb_q[0], br_q);
  end

  // Next-state and datapath control for the IDLE/SHIFT sequencer.
  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    res_d    = res_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    diff_d   = diff_q;
    borrow_d = borrow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          res_d   = '0;
          br_d    = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          busy_d  = 1'b0;
        end
      end

      SHIFT: begin
        // The new bit enters at the MSB. After WIDTH shifts, the first bit sits at bit 0.
        res_d = {bit_diff, res_q[WIDTH-1:1]};
        sa_d  = {1'b0, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        br_d  = bit_borrow;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          // Publish the completed word. diff never shows partial results.
          diff_d   = {bit_diff, res_q[WIDTH-1:1]};
          borrow_d = bit_borrow;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = IDLE;
        end else begin
          busy_d   = 1'b1;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset discards any operation in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      res_q    <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      res_q    <= res_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and random checks for serial_subtractor with WIDTH=8.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;

  int n_cmp    = 0;
  int n_err    = 0;
  int done_cnt = 0;

  // Count every cycle in which done is high. Sampling happens on the falling edge.
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt <= done_cnt + 1;
  end

  typedef struct {
    logic [WIDTH-1:0] va;
    logic [WIDTH-1:0] vb;
    logic [WIDTH-1:0] exp_diff;
    logic             exp_bor;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive a single start with operands, then wait for done. The wait is bounded.
  // On return, the current falling edge is the done cycle.
  task automatic run_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        output int lat, output int busy_cycles);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    lat = 0;
    busy_cycles = 0;
    while (done !== 1'b1 && lat < 40) begin
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
      lat++;
    end
  endtask

  int lat, bc, k, m, d0, gap;
  logic [WIDTH-1:0] ra, rb;

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset diff", 32'(diff), 32'd0);
    check("reset borrow", 32'(borrow_out), 32'd0);
    rst = 1'b0;

    vecs[0] = '{8'd200, 8'd55,  8'd145, 1'b0};
    vecs[1] = '{8'd5,   8'd9,   8'd252, 1'b1};
    vecs[2] = '{8'd0,   8'd0,   8'd0,   1'b0};
    vecs[3] = '{8'd255, 8'd255, 8'd0,   1'b0};
    vecs[4] = '{8'd0,   8'd1,   8'd255, 1'b1};
    vecs[5] = '{8'd255, 8'd0,   8'd255, 1'b0};
    vecs[6] = '{8'd170, 8'd85,  8'd85,  1'b0};
    vecs[7] = '{8'd85,  8'd170, 8'd171, 1'b1};

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].va, vecs[i].vb, lat, bc);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'd8);
      check($sformatf("vec%0d busy cycles", i), 32'(bc), 32'd8);
      check($sformatf("vec%0d busy at done", i), 32'(busy), 32'd0);
      check($sformatf("vec%0d diff", i), 32'(diff), 32'(vecs[i].exp_diff));
      check($sformatf("vec%0d borrow", i), 32'(borrow_out), 32'(vecs[i].exp_bor));
    end

    // diff holds 252 across 20 idle cycles, and no stray done appears.
    run_op(8'd5, 8'd9, lat, bc);
    check("hold first diff", 32'(diff), 32'd252);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("hold diff c%0d", i), 32'(diff), 32'd252);
      check($sformatf("hold done c%0d", i), 32'(done), 32'd0);
    end
    check("hold borrow", 32'(borrow_out), 32'd1);

    // A start while busy is ignored. A start in the done cycle is accepted.
    @(negedge clk);
    a = 8'd100; b = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    repeat (2) begin @(negedge clk); k++; end
    a = 8'd7; b = 8'd7; start = 1'b1;
    @(negedge clk); k++;
    start = 1'b0;
    while (done !== 1'b1 && k < 40) begin @(negedge clk); k++; end
    check("ignored start latency", 32'(k), 32'd8);
    check("ignored start diff", 32'(diff), 32'd99);
    check("ignored start borrow", 32'(borrow_out), 32'd0);
    a = 8'd7; b = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m = 1;
    check("done single cycle", 32'(done), 32'd0);
    check("busy after done-cycle start", 32'(busy), 32'd1);
    while (done !== 1'b1 && m < 40) begin @(negedge clk); m++; end
    check("back-to-back spacing", 32'(m), 32'd9);
    check("back-to-back diff", 32'(diff), 32'd0);

    // A reset in mid-operation discards the partial result.
    run_op(8'd200, 8'd55, lat, bc);
    check("pre-reset diff", 32'(diff), 32'd145);
    @(negedge clk);
    a = 8'd50; b = 8'd20; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid-reset busy", 32'(busy), 32'd0);
    check("mid-reset done", 32'(done), 32'd0);
    check("mid-reset diff", 32'(diff), 32'd0);
    check("mid-reset borrow", 32'(borrow_out), 32'd0);
    d0 = done_cnt;
    repeat (12) @(negedge clk);
    check("no done after reset", 32'(done_cnt - d0), 32'd0);
    run_op(8'd50, 8'd20, lat, bc);
    check("post-reset latency", 32'(lat), 32'd8);
    check("post-reset diff", 32'(diff), 32'd30);
    check("post-reset borrow", 32'(borrow_out), 32'd0);

    // Random operands, with random idle gaps between operations.
    @(negedge clk);
    d0 = done_cnt;
    for (int i = 0; i < 1000; i++) begin
      gap = int'($urandom_range(0, 3));
      repeat (gap) @(negedge clk);
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      run_op(ra, rb, lat, bc);
      check($sformatf("rnd%0d diff a=%0d b=%0d", i, ra, rb), 32'(diff), 32'(8'(ra - rb)));
      check($sformatf("rnd%0d borrow a=%0d b=%0d", i, ra, rb), 32'(borrow_out), 32'(ra < rb));
    end
    @(negedge clk);
    check("random done count", 32'(done_cnt - d0), 32'd1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
